demux_1x2_reg: RTL and testbench
================================

# demux_1x2_reg

Registered 1-to-2 demultiplexer with valid/ready handshaking: steers one input word to output channel A or B according to a select bit and holds it in a per-channel output register until that channel's consumer accepts it. It is the distribution counterpart of the datapath's 2-to-1 selection muxes. It fans a single producer, such as a writeback or result stream, out to two sinks. Per-channel transfer counters support debug and verification.

## Interface
- `Bits`, 32, width of data path.
- `CntBits`, 16, width of each per-channel transfer counter.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  Bits  word to route.
- `in_sel`  input  1  route select: 0 to channel A, 1 to channel B (same polarity as the 2-to-1 mux: sel=0 selects `a`).
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  block accepts the word this cycle.
- `a_data`, `b_data`  output  Bits  registered channel data.
- `a_valid`, `b_valid`  output  1  channel register holds a word.
- `a_ready`, `b_ready`  input  1  consumer accepts the channel word.
- `a_count`, `b_count`  output  CntBits  number of words accepted into each channel; wraps modulo 2^CntBits.

## Operation
- Each channel has one holding register: data plus a valid flag.
- Channel X is free when `x_valid`=0 or `x_ready`=1.
- `in_ready` = (`in_sel`=0 ? A free : B free).
  - It is combinational from `in_sel`, `a_valid`, `a_ready`, `b_valid` and `b_ready`.
  - It does not depend on `in_valid`.
- An input transfer occurs when `in_valid`=1 and `in_ready`=1.
  - On a transfer, the selected channel's register loads `in_data` and its valid flag is set.
  - The selected channel's counter increments by 1.
- An output drain occurs when `x_valid`=1 and `x_ready`=1.
  - If there is no fill into X in the same cycle, `x_valid` clears.
  - `x_data` keeps its last value after the drain; it is not cleared.
- Fill and drain on the same channel in the same cycle: the new word is loaded and `x_valid` stays 1. This gives full throughput of 1 word/cycle per channel.
- The unselected channel is unaffected by input activity. It can drain independently in the same cycle as a fill of the other channel.
- Producer rule: `in_data` and `in_sel` stay stable while `in_valid`=1 and `in_ready`=0.
  - The block does not check this rule.
  - The bench asserts it on the producer side.
- Counters wrap from 2^CntBits-1 to 0 with no flag.
- Reset, asynchronous and taking effect immediately on `rst`=1:
  - `a_valid`, `b_valid` = 0.
  - `a_data`, `b_data` = 0.
  - `a_count`, `b_count` = 0.
  - Any held word is discarded.
  - While `rst`=1, `in_ready` follows its formula with both channels empty, so it reads 1. No transfer is registered until the cycle after `rst` deasserts.

## Timing
- Latency: a word accepted at edge N is presented on `x_data`/`x_valid` right after edge N. It is consumable at edge N+1 at the earliest.
- Sustained throughput: 1 word/cycle into either channel while that channel's consumer holds `x_ready`=1.
- A channel stalled with `x_valid`=1 and `x_ready`=0 blocks only inputs selecting that channel. Inputs selecting the other channel proceed.
- The only combinational paths are from `in_sel` and `x_ready` to `in_ready`. There is no path from input to output data or valid.
- All state updates on the rising edge of `clk`, except the asynchronous reset.

## Test plan
- Reset, then `in_valid`=1, `in_sel`=0, `in_data`=0x11111111, with `a_ready`=1 → after 1 edge: `a_valid`=1, `a_data`=0x11111111, `a_count`=1; `b_valid`=0 and `b_count`=0.
- Hold `b_ready`=0 and send 0xB0 with `in_sel`=1 → `b_valid`=1. A second word with `in_sel`=1 sees `in_ready`=0. A word with `in_sel`=0 is still accepted into A that cycle.
- Streaming: 8 words 0..7 alternating `in_sel`, both readies 1 → `in_ready` stays 1 every cycle. Each channel delivers its words in order. `a_count`=4, `b_count`=4.
- Same-cycle fill and drain: `a_valid`=1 holding 0x5, `a_ready`=1, new word 0x6 with `in_sel`=0 → next cycle `a_valid`=1, `a_data`=0x6; no bubble.
- Counter wrap with `CntBits`=4: 17 transfers to B → `b_count`=1.
- Reset mid-operation: `a_valid`=1 and `b_valid`=1 with data 0xDEAD/0xBEEF, assert `rst` between edges → both valids, both data and both counts read 0 before the next `clk` edge. `in_ready`=1.

Source files
------------

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demux: steers in_data to channel A (in_sel=0) or B (in_sel=1).
// Latency: one cycle from input transfer to x_valid/x_data; full 1 word/cycle per channel.
// Backpressure: in_ready reflects only the selected channel being free; a stalled channel never blocks the other.
module demux_1x2_reg #(
    parameter int Bits    = 32,
    parameter int CntBits = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [Bits-1:0]    in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [Bits-1:0]    a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [CntBits-1:0] a_count,
    output logic [Bits-1:0]    b_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [CntBits-1:0] b_count
);

    logic a_free;
    logic b_free;
    logic a_fill;
    logic b_fill;

    // A channel is free if empty or being drained this cycle, enabling fill+drain in one cycle.
    assign a_free   = !a_valid || a_ready;
    assign b_free   = !b_valid || b_ready;
    assign in_ready = in_sel ? b_free : a_free;
    assign a_fill   = in_valid && in_ready && !in_sel;
    assign b_fill   = in_valid && in_ready &&  in_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data  <= '0;
            a_valid <= 1'b0;
            a_count <= '0;
        end else if (a_fill) begin
            a_data  <= in_data;
            a_valid <= 1'b1;
            a_count <= a_count + CntBits'(1);
        end else if (a_ready) begin
            // Drain only clears the flag; the data keeps its last value.
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data  <= '0;
            b_valid <= 1'b0;
            b_count <= '0;
        end else if (b_fill) begin
            b_data  <= in_data;
            b_valid <= 1'b1;
            b_count <= b_count + CntBits'(1);
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Bench for demux_1x2_reg: vector table plus per-channel scoreboard queues and hand sequences.
module tb_demux_1x2_reg;

    localparam int CB = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a_data;
    logic          a_valid;
    logic          a_ready;
    logic [CB-1:0] a_count;
    logic [31:0]   b_data;
    logic          b_valid;
    logic          b_ready;
    logic [CB-1:0] b_count;

    demux_1x2_reg #(.Bits(32), .CntBits(CB)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_count(a_count),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pre_rst;
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        rdy;
        logic        av;
        logic        bv;
    } vec_t;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [CB-1:0] mac;
    logic [CB-1:0] mbc;
    logic        mav;
    logic        mbv;
    vec_t        tbl[18];

    // Producer-side rule: a stalled word must be held unchanged.
    logic        p_v, p_r, p_s;
    logic [31:0] p_d;
    always @(posedge clk) begin
        if (!rst && p_v && !p_r)
            assert (in_valid && in_data == p_d && in_sel == p_s)
            else $error("producer changed a stalled word");
        p_v <= in_valid && !rst;
        p_r <= in_ready;
        p_d <= in_data;
        p_s <= in_sel;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic pr, input logic v, input logic sel, input logic [31:0] d,
                                input logic ar, input logic br, input logic rdy,
                                input logic av, input logic bv);
        vec_t t;
        t.pre_rst = pr; t.v = v; t.sel = sel; t.d = d; t.ar = ar; t.br = br;
        t.rdy = rdy; t.av = av; t.bv = bv;
        return t;
    endfunction

    // Entered just after a rising edge; asserts reset between edges and checks the cleared state.
    task automatic do_reset();
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        check("rst_a_data",  a_data, 0);
        check("rst_b_data",  b_data, 0);
        check("rst_a_count", 32'(a_count), 0);
        check("rst_b_count", 32'(b_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        mac = '0; mbc = '0; mav = 1'b0; mbv = 1'b0;
    endtask

    // One clock of stimulus: scoreboard drains/pushes before the edge, state checks after it.
    task automatic apply(input vec_t t);
        in_valid = t.v; in_sel = t.sel; in_data = t.d; a_ready = t.ar; b_ready = t.br;
        #3;
        check("in_ready", 32'(in_ready), 32'(t.rdy));
        if (mav && t.ar) begin
            if (qa.size() == 0) check("a_drain_underflow", 1, 0);
            else check("a_drain_data", a_data, qa.pop_front());
        end
        if (mbv && t.br) begin
            if (qb.size() == 0) check("b_drain_underflow", 1, 0);
            else check("b_drain_data", b_data, qb.pop_front());
        end
        if (t.v && t.rdy) begin
            if (t.sel) begin qb.push_back(t.d); mbc++; end
            else       begin qa.push_back(t.d); mac++; end
        end
        @(posedge clk); #1;
        mav = t.av; mbv = t.bv;
        check("a_valid", 32'(a_valid), 32'(t.av));
        check("b_valid", 32'(b_valid), 32'(t.bv));
        check("a_count", 32'(a_count), 32'(mac));
        check("b_count", 32'(b_count), 32'(mbc));
        if (t.av && qa.size() > 0) check("a_data_held", a_data, qa[0]);
        if (t.bv && qb.size() > 0) check("b_data_held", b_data, qb[0]);
    endtask

    initial begin
        //            rst v  sel d             ar br rdy av bv
        tbl[0]  = mk(1, 1, 0, 32'h11111111, 1, 1, 1, 1, 0);
        tbl[1]  = mk(0, 1, 1, 32'h000000B0, 1, 0, 1, 0, 1);
        tbl[2]  = mk(0, 1, 0, 32'h000000A0, 0, 0, 1, 1, 1);
        tbl[3]  = mk(0, 1, 1, 32'h000000B1, 0, 0, 0, 1, 1);
        tbl[4]  = mk(0, 1, 1, 32'h000000B1, 1, 1, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 0, 0);
        tbl[6]  = mk(1, 1, 0, 32'd0,        1, 1, 1, 1, 0);
        tbl[7]  = mk(0, 1, 1, 32'd1,        1, 1, 1, 0, 1);
        tbl[8]  = mk(0, 1, 0, 32'd2,        1, 1, 1, 1, 0);
        tbl[9]  = mk(0, 1, 1, 32'd3,        1, 1, 1, 0, 1);
        tbl[10] = mk(0, 1, 0, 32'd4,        1, 1, 1, 1, 0);
        tbl[11] = mk(0, 1, 1, 32'd5,        1, 1, 1, 0, 1);
        tbl[12] = mk(0, 1, 0, 32'd6,        1, 1, 1, 1, 0);
        tbl[13] = mk(0, 1, 1, 32'd7,        1, 1, 1, 0, 1);
        tbl[14] = mk(0, 0, 0, 32'h0,        1, 1, 1, 0, 0);
        tbl[15] = mk(1, 1, 0, 32'h5,        0, 0, 1, 1, 0);
        tbl[16] = mk(0, 1, 0, 32'h6,        1, 0, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,        1, 0, 1, 0, 0);

        rst = 1'b1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].pre_rst && i != 0) do_reset();
            apply(tbl[i]);
            if (i == 13) begin
                check("stream_a_count", 32'(a_count), 4);
                check("stream_b_count", 32'(b_count), 4);
            end
        end

        // 17 back-to-back transfers into B wrap the 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++)
            apply(mk(0, 1, 1, 32'h100 + 32'(i), 1, 1, 1, 0, 1));
        check("wrap_b_count", 32'(b_count), 1);
        check("wrap_a_count", 32'(a_count), 0);

        // Both channels stalled holding words, then reset asserted between edges.
        do_reset();
        apply(mk(0, 1, 0, 32'hDEAD, 0, 0, 1, 1, 0));
        apply(mk(0, 1, 1, 32'hBEEF, 0, 0, 1, 1, 1));
        check("pre_rst_a_data", a_data, 32'hDEAD);
        check("pre_rst_b_data", b_data, 32'hBEEF);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
